// File: rtl/vga_sync_monitor.sv
// Receiving-end checker for a VGA sync/colour stream: measures line and frame
// timing against nominal values, tracks lock, and counts lit pixels per frame.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic        vga_r,
    input  logic        vga_g,
    input  logic        vga_b,
    output logic [10:0] h_pos,
    output logic [9:0]  v_pos,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic [18:0] lit_count,
    output logic        frame_done,
    output logic        locked,
    output logic        sync_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam logic [10:0] H_MAX   = 11'h7FF;
    localparam logic [9:0]  V_MAX   = 10'h3FF;
    localparam logic [18:0] LIT_MAX = 19'h7FFFF;
    localparam logic [10:0] H_NOM   = 11'(H_TOTAL);
    localparam logic [9:0]  V_NOM   = 10'(V_TOTAL);
    localparam logic [7:0]  LOCK_N  = 8'(LOCK_FRAMES);

    // Input sample registers plus one delay stage for falling-edge detection
    logic r_hs, r_vs, r_hs_d, r_vs_d;
    logic r_r, r_g, r_b;

    logic [10:0] r_h_pos, r_line_len;
    logic        r_h_seen, r_line_upd, r_h_lost;

    logic [9:0]  r_v_pos, r_frame_lines;
    logic [18:0] r_lit_run, r_lit_count;
    logic        r_v_seen, r_frame_done;

    logic        r_lines_ok, r_frame_ok_snap;

    lock_state_t r_state, w_state_nxt;
    logic [7:0]  r_good_cnt, w_good_cnt_nxt;
    logic        r_locked, r_sync_err;
    logic        w_locked_nxt, w_sync_err_nxt;

    logic        w_h_fall, w_v_fall, w_lit;
    logic [10:0] w_h_inc;
    logic [9:0]  w_v_inc;
    logic [18:0] w_lit_inc;
    logic [7:0]  w_good_inc;
    logic        w_line_bad, w_frame_good, w_frame_bad, w_bad_event;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_hs_d <= 1'b1;
            r_vs_d <= 1'b1;
            r_r    <= 1'b0;
            r_g    <= 1'b0;
            r_b    <= 1'b0;
        end else begin
            r_hs   <= vga_h_sync;
            r_vs   <= vga_v_sync;
            r_hs_d <= r_hs;
            r_vs_d <= r_vs;
            r_r    <= vga_r;
            r_g    <= vga_g;
            r_b    <= vga_b;
        end
    end

    assign w_h_fall  = r_hs_d & ~r_hs;
    assign w_v_fall  = r_vs_d & ~r_vs;
    assign w_lit     = r_r | r_g | r_b;
    assign w_h_inc   = (r_h_pos == H_MAX) ? H_MAX : r_h_pos + 11'd1;
    assign w_v_inc   = (r_v_pos == V_MAX) ? V_MAX : r_v_pos + 10'd1;
    assign w_lit_inc = (r_lit_run == LIT_MAX) ? LIT_MAX : r_lit_run + 19'd1;

    // Horizontal measurement; line_len only trusted once a previous edge exists
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h_pos    <= 11'd0;
            r_line_len <= 11'd0;
            r_h_seen   <= 1'b0;
            r_line_upd <= 1'b0;
            r_h_lost   <= 1'b0;
        end else begin
            r_line_upd <= w_h_fall & r_h_seen;
            r_h_lost   <= ~w_h_fall & (r_h_pos == H_MAX - 11'd1);
            if (w_h_fall) begin
                r_h_pos  <= 11'd0;
                r_h_seen <= 1'b1;
                if (r_h_seen) begin
                    r_line_len <= w_h_inc;
                end
            end else begin
                r_h_pos <= w_h_inc;
            end
        end
    end

    // A vsync edge closes the frame before any coincident hsync edge counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v_pos       <= 10'd0;
            r_frame_lines <= 10'd0;
            r_lit_run     <= 19'd0;
            r_lit_count   <= 19'd0;
            r_v_seen      <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_v_fall) begin
                r_v_pos   <= 10'd0;
                r_lit_run <= 19'd0;
                r_v_seen  <= 1'b1;
                if (r_v_seen) begin
                    r_frame_lines <= r_v_pos;
                    r_lit_count   <= r_lit_run;
                    r_frame_done  <= 1'b1;
                end
            end else begin
                if (w_h_fall) begin
                    r_v_pos <= w_v_inc;
                end
                if (w_lit) begin
                    r_lit_run <= w_lit_inc;
                end
            end
        end
    end

    assign w_line_bad = r_line_upd & (r_line_len != H_NOM);

    // Sticky "all lines good" flag, snapshotted when the frame closes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lines_ok      <= 1'b0;
            r_frame_ok_snap <= 1'b0;
        end else if (w_v_fall) begin
            r_lines_ok      <= 1'b1;
            r_frame_ok_snap <= r_lines_ok & ~w_line_bad;
        end else if (w_line_bad) begin
            r_lines_ok <= 1'b0;
        end
    end

    assign w_frame_good = r_frame_done & (r_frame_lines == V_NOM) & r_frame_ok_snap;
    assign w_frame_bad  = r_frame_done & ~w_frame_good;
    assign w_bad_event  = w_line_bad | w_frame_bad | r_h_lost;
    assign w_good_inc   = (r_good_cnt == 8'hFF) ? 8'hFF : r_good_cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= UNLOCKED;
            r_good_cnt <= 8'd0;
            r_locked   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
            r_locked   <= w_locked_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        case (r_state)
            UNLOCKED: begin
                if (w_frame_good) begin
                    w_good_cnt_nxt = 8'd1;
                    w_state_nxt    = (LOCK_N <= 8'd1) ? LOCKED : LOCKING;
                end
            end
            LOCKING: begin
                if (w_bad_event) begin
                    w_good_cnt_nxt = 8'd0;
                    w_state_nxt    = UNLOCKED;
                end else if (w_frame_good) begin
                    w_good_cnt_nxt = w_good_inc;
                    if (w_good_inc >= LOCK_N) begin
                        w_state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_bad_event) begin
                    w_good_cnt_nxt = 8'd0;
                    w_state_nxt    = UNLOCKED;
                end
            end
            default: begin
                w_good_cnt_nxt = 8'd0;
                w_state_nxt    = UNLOCKED;
            end
        endcase
    end

    always_comb begin
        w_locked_nxt   = (r_state == LOCKED);
        w_sync_err_nxt = 1'b0;
        if ((r_state != UNLOCKED) && w_bad_event) begin
            w_sync_err_nxt = 1'b1;
        end
    end

    assign h_pos       = r_h_pos;
    assign v_pos       = r_v_pos;
    assign line_len    = r_line_len;
    assign frame_lines = r_frame_lines;
    assign lit_count   = r_lit_count;
    assign frame_done  = r_frame_done;
    assign locked      = r_locked;
    assign sync_err    = r_sync_err;
    assign dbg_state   = r_state;

endmodule
